writeback_unit: RTL and testbench

- Write-back stage; consumes the execution stage's registered result/valid pair and commits it to the integer register file write port.
- Holds a small in-order result queue so register-file stalls do not lose results.
- Drops writes to x0.
- Provides a retire counter and a sticky overflow flag for debug.

---
 rtl/writeback_unit.sv | 127 ++++++++++++
 tb/tb_writeback_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// Write-back stage: small in-order result queue feeding the integer RF write port.
// Optional WB_BYPASS_EN adds a combinational youngest-match lookup into the queue.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module writeback_unit #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int DEPTH      = 4,
  parameter int RF_ADDR_W  = 5,
  parameter int CNT_W      = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   exe_valid_in,
  input  logic [DATA_WIDTH-1:0]  exe_result,
  input  logic [RF_ADDR_W-1:0]   exe_rd,
  output logic                   exe_ready,
  input  logic                   system_stall,
  input  logic                   rf_wr_ready,
  output logic                   rf_wr_en,
  output logic [RF_ADDR_W-1:0]   rf_wr_addr,
  output logic [DATA_WIDTH-1:0]  rf_wr_data,
  output logic [$clog2(DEPTH):0] wb_occupancy,
  output logic [CNT_W-1:0]       retire_cnt,
  output logic                   wb_overflow
`ifdef WB_BYPASS_EN
  ,
  input  logic [RF_ADDR_W-1:0]   byp_rd_query,
  output logic                   byp_valid,
  output logic [RF_ADDR_W-1:0]   byp_rd,
  output logic [DATA_WIDTH-1:0]  byp_data
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef struct packed {
    logic [RF_ADDR_W-1:0]  rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [CNT_W-1:0]      retire_q, retire_d;
  logic                  ovf_q, ovf_d;

  logic      empty, accept, push, x0_drop, pop;
  wb_entry_t head;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    // Readiness comes only from registered occupancy: no same-cycle pass-through.
    exe_ready = (occ_q != OCC_W'(DEPTH));
    empty     = (occ_q == '0);
    accept    = exe_valid_in && exe_ready;
    push      = accept && (exe_rd != '0);
    x0_drop   = accept && (exe_rd == '0);

    head       = mem_q[rd_ptr_q];
    rf_wr_en   = !empty && !system_stall;
    rf_wr_addr = empty ? '0 : head.rd;
    rf_wr_data = empty ? '0 : head.data;
    pop        = rf_wr_en && rf_wr_ready;

    if (push) begin
      mem_d[wr_ptr_q] = '{rd: exe_rd, data: exe_result};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop)
      rd_ptr_d = rd_ptr_q + PTR_W'(1);

    occ_d    = occ_q + OCC_W'(push) - OCC_W'(pop);
    retire_d = retire_q + CNT_W'(pop) + CNT_W'(x0_drop);
    ovf_d    = ovf_q || (exe_valid_in && !exe_ready);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      retire_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      retire_q <= retire_d;
      ovf_q    <= ovf_d;
    end
  end

  assign wb_occupancy = occ_q;
  assign retire_cnt   = retire_q;
  assign wb_overflow  = ovf_q;

`ifdef WB_BYPASS_EN
  logic [PTR_W-1:0] byp_idx;

  // Walk oldest to newest so the last hit is the youngest; registered entries only.
  always_comb begin
    byp_valid = 1'b0;
    byp_rd    = '0;
    byp_data  = '0;
    byp_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      byp_idx = rd_ptr_q + PTR_W'(i);
      if ((OCC_W'(i) < occ_q) && (byp_rd_query != '0) &&
          (mem_q[byp_idx].rd == byp_rd_query)) begin
        byp_valid = 1'b1;
        byp_rd    = mem_q[byp_idx].rd;
        byp_data  = mem_q[byp_idx].data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: queue-based reference model, directed plan plus random traffic.
module tb_writeback_unit;
  localparam int DW = 32, DEPTH = 4, AW = 5, CW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          exe_valid_in = 1'b0;
  logic [DW-1:0] exe_result = '0;
  logic [AW-1:0] exe_rd = '0;
  logic          system_stall = 1'b0;
  logic          rf_wr_ready = 1'b0;
  logic          exe_ready, rf_wr_en, wb_overflow;
  logic [AW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_wr_data;
  logic [$clog2(DEPTH):0] wb_occupancy;
  logic [CW-1:0] retire_cnt;
`ifdef WB_BYPASS_EN
  logic [AW-1:0] byp_rd_query = '0;
  logic          byp_valid;
  logic [AW-1:0] byp_rd;
  logic [DW-1:0] byp_data;
`endif

  writeback_unit #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .RF_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .exe_valid_in(exe_valid_in), .exe_result(exe_result), .exe_rd(exe_rd),
    .exe_ready(exe_ready), .system_stall(system_stall), .rf_wr_ready(rf_wr_ready),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .wb_occupancy(wb_occupancy), .retire_cnt(retire_cnt), .wb_overflow(wb_overflow)
`ifdef WB_BYPASS_EN
    , .byp_rd_query(byp_rd_query), .byp_valid(byp_valid), .byp_rd(byp_rd), .byp_data(byp_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          exp_q[$];
  int            n_tests = 0, n_fail = 0;
  logic [CW-1:0] m_retire = '0;
  bit            m_ovf = 1'b0;
  bit            mon_en = 1'b0;
  int            snap_occ = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs against model state each cycle, retires on handshake.
  initial begin
    bit exp_en;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        m_retire = '0;
        m_ovf    = 1'b0;
        snap_occ = 0;
        mon_en   = 1'b1;
      end else if (mon_en) begin
        snap_occ = exp_q.size();
        exp_en   = (snap_occ != 0) && !system_stall;
        chk("wb_occupancy", wb_occupancy, snap_occ);
        chk("exe_ready", exe_ready, snap_occ != DEPTH);
        chk("retire_cnt", retire_cnt, m_retire);
        chk("wb_overflow", wb_overflow, m_ovf);
        chk("rf_wr_en", rf_wr_en, exp_en);
        if (snap_occ != 0) begin
          chk("rf_wr_addr", rf_wr_addr, exp_q[0].rd);
          chk("rf_wr_data", rf_wr_data, exp_q[0].data);
        end else begin
          chk("rf_wr_addr_empty", rf_wr_addr, 0);
          chk("rf_wr_data_empty", rf_wr_data, 0);
        end
`ifdef WB_BYPASS_EN
        begin
          bit            bv = 1'b0;
          logic [AW-1:0] br = '0;
          logic [DW-1:0] bd = '0;
          if (byp_rd_query != 0)
            for (int i = exp_q.size() - 1; i >= 0; i--)
              if (!bv && exp_q[i].rd == byp_rd_query) begin
                bv = 1'b1; br = exp_q[i].rd; bd = exp_q[i].data;
              end
          chk("byp_valid", byp_valid, bv);
          chk("byp_rd", byp_rd, br);
          chk("byp_data", byp_data, bd);
        end
`endif
        if (exp_en && rf_wr_ready) begin
          void'(exp_q.pop_front());
          m_retire++;
        end
      end
    end
  end

  // One clock of stimulus; the expected effect is pushed once the cycle's inputs are final.
  task automatic cyc(input bit v, input logic [AW-1:0] rd, input logic [DW-1:0] d,
                     input bit st, input bit rdy, input bit rst);
    @(posedge clk);
    #1;
    exe_valid_in = v;
    exe_rd       = rd;
    exe_result   = d;
    system_stall = st;
    rf_wr_ready  = rdy;
    reset        = rst;
`ifdef WB_BYPASS_EN
    byp_rd_query = AW'($urandom_range(0, 7));
`endif
    @(negedge clk);
    #1;
    if (!reset && mon_en && exe_valid_in) begin
      if (snap_occ == DEPTH) m_ovf = 1'b1;
      else if (exe_rd == 0)  m_retire++;
      else begin
        ent_t e;
        e.rd = exe_rd; e.data = exe_result;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, rdy, 0);
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    idle(1, 1);
    chk("reset_retire", retire_cnt, 0);
    chk("reset_ready", exe_ready, 1);

    // single result, then x0 drop
    cyc(1, 5, 32'h0000_00AA, 0, 1, 0);
    idle(2, 1);
    cyc(1, 0, 32'hDEAD_BEEF, 0, 1, 0);
    idle(2, 1);

    // backpressure fill and overflow
    for (int i = 1; i <= 4; i++) cyc(1, AW'(i), DW'(i * 'h11), 0, 0, 0);
    cyc(1, 5, 32'h55, 0, 0, 0);
    idle(6, 1);
    chk("overflow_sticky", wb_overflow, 1);

    // stall holds commit but not enqueue
    cyc(1, 7, 32'h77, 1, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 1, 0);
    idle(2, 1);

    // back-to-back stream with pointer wrap
    for (int i = 0; i < 10; i++) cyc(1, AW'(8 + i), DW'(32'h1000 + i), 0, 1, 0);
    idle(2, 1);

    // reset mid-operation
    for (int i = 0; i < 3; i++) cyc(1, AW'(20 + i), DW'(i), 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    idle(1, 0);
    chk("midreset_occ", wb_occupancy, 0);
    chk("midreset_ovf", wb_overflow, 0);

    // random traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 299) == 0);
    idle(8, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
